cam_sccb_config: RTL and testbench
==================================

Name: cam_sccb_config

Overview:
- Sequences camera power-up and register configuration over the camera's SCCB (I2C-like, write-only) serial bus.
- Walks an external register table of {reg, data} entries and issues one 3-phase SCCB write per entry.
- Sits beside the camera capture path in the FPGA fabric and drives the camera reset/powerdown pins and SIO_C/SIO_D.
- Software or a top-level pulse triggers it through `start`.

Parameters:
- QUARTER_CYC, 125: clk cycles per quarter SCCB bit; 100 kHz SCCB clock at 50 MHz.
- POWERUP_CYC, 50000: cycles cam_rst_n is held low, and then high, before the first transaction (1 ms each).
- DELAY_CYC, 500000: cycles waited on a delay table entry (10 ms).
- DEV_ID, 8'h42: SCCB write address byte.
- TAW, 8: table address width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse that begins a full configuration run
- busy  out  1  high from accepted start until done
- done  out  1  high after a run completes; cleared by the next accepted start
- tbl_addr  out  TAW  table index
- tbl_data  in  16  {reg[15:8], data[7:0]}; synchronous ROM, valid 1 cycle after tbl_addr changes
- sio_c  out  1  SCCB clock, push-pull
- sio_d_oe  out  1  1 = drive SIO_D low; 0 = release (pulled high at top level)
- cam_rst_n  out  1  camera reset, active low
- cam_pwdn  out  1  camera powerdown, active high
- wr_count  out  TAW  number of register writes completed in the current run

Behaviour:
- Reset values: busy=0, done=0, tbl_addr=0, sio_c=1, sio_d_oe=0, cam_rst_n=1, cam_pwdn=0, wr_count=0. FSM goes to IDLE.
- Reset asserted mid-transaction: SCCB lines are released immediately and asynchronously; no stop condition is generated.
- start is accepted only in IDLE or DONE_ST. While busy, start is ignored.
- Accepted start sets busy=1, clears done, zeroes tbl_addr and wr_count, then enters PWR_LO.

FSM states and transitions:
- PWR_LO: cam_rst_n=0 for POWERUP_CYC cycles, then PWR_HI.
- PWR_HI: cam_rst_n=1 for POWERUP_CYC cycles, then FETCH.
- FETCH: wait 1 cycle for ROM data, then DECODE.
- DECODE:
  - tbl_data==16'hFFFF → DONE_ST.
  - tbl_data==16'hFFF0 → DELAY.
  - Otherwise → START, latching shift bytes {DEV_ID, reg, data}.
- DELAY: count DELAY_CYC cycles, tbl_addr+1, then FETCH.
- START, from idle bus levels:
  - q0–q1: sio_c=1, sio_d_oe=0.
  - q2: sio_d_oe=1 (SIO_D falls while SIO_C high).
  - q3: sio_c=0.
  - Then SHIFT.
- SHIFT: 3 bytes × 9 bits, MSB first. Each bit is 4 quarters:
  - q0: set sio_d_oe = ~bit with sio_c=0.
  - q1: sio_c=0.
  - q2–q3: sio_c=1.
  - 9th bit of each byte: sio_d_oe=0 (don't-care phase). The level is not sampled and there is no error path.
- STOP:
  - q0: sio_c=0, sio_d_oe=1.
  - q1: sio_c=1.
  - q2: sio_d_oe=0 (SIO_D rises while SIO_C high).
  - q3: hold.
  - Then GAP.
- GAP: 4 quarters idle with bus released. Then wr_count+1, tbl_addr+1, FETCH.
- DONE_ST: busy=0, done=1, bus released. Stays until reset or the next start.

Rules and boundary conditions:
- Timing: one transaction = 4 + 108 + 4 + 4 = 120 quarters = 120·QUARTER_CYC cycles, plus 2 cycles FETCH/DECODE.
- Quarter counter: reloads at QUARTER_CYC-1, decrements to 0, advances the phase on 0.
- tbl_addr wraps: reaching 2^TAW-1 without an end marker forces DONE_ST after that entry is processed, with no wrap to 0.
- wr_count saturates at 2^TAW-1. It never counts delay or end entries.
- cam_pwdn is constant 0 after reset.
- Entry reg=8'hFF with any data other than 8'hFF or 8'hF0 is written as a normal register write.

Test Plan (QUARTER_CYC=2, POWERUP_CYC=10, DELAY_CYC=20):
1. Reset, then start; table[0]=16'hFFFF → cam_rst_n low for exactly 10 cycles, high 10 cycles; done=1 and busy=0 with wr_count=0; no SIO_C edges.
2. Table {16'h1280, 16'hFFFF}, monitor decodes the bus → start condition, bytes 0x42, 0x12, 0x80; sio_d_oe=0 on each 9th bit; stop condition; wr_count=1. Transaction spans 240 cycles from START entry to GAP end.
3. Table {16'h1101, 16'hFFF0, 16'h6B4A, 16'hFFFF} → 20-cycle idle gap with bus released between the two writes; wr_count=2; tbl_addr ends at 3.
4. Pulse start while busy in SHIFT → ignored: same byte stream, a single done rising edge.
5. Assert reset_n low in SHIFT bit 5 of the reg byte → sio_c=1, sio_d_oe=0 and busy=0 in the same cycle (asynchronous). A new start then reruns from tbl_addr=0 with the power-up sequence.
6. TAW=2, table with no end marker {16'h0101, 16'h0202, 16'h0303, 16'h0404} → four writes, then done=1 with tbl_addr=3 and wr_count=3 (saturated).

Source files
------------

// File: rtl/cam_sccb_config.sv
// cam_sccb_config: camera power-up sequencer that walks a {reg,data} table
// and issues one SCCB 3-phase write per entry.
module cam_sccb_config #(
    parameter int         QUARTER_CYC = 125,
    parameter int         POWERUP_CYC = 50000,
    parameter int         DELAY_CYC   = 500000,
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         TAW         = 8
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [TAW-1:0] tbl_addr_o,
    input  logic [15:0]    tbl_data_i,
    output logic           sio_c_o,
    output logic           sio_d_oe_o,
    output logic           cam_rst_n_o,
    output logic           cam_pwdn_o,
    output logic [TAW-1:0] wr_count_o
);
    localparam int MAXA = (DELAY_CYC > POWERUP_CYC) ? DELAY_CYC : POWERUP_CYC;
    localparam int MAXC = (MAXA > QUARTER_CYC) ? MAXA : QUARTER_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [3:0] {
        IDLE, PWR_LO, PWR_HI, FETCH, DECODE, DELAY, START, SHIFT, STOP, GAP, DONE_ST
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     ph_q, ph_d;
    logic [3:0]     bit_q, bit_d;
    logic [1:0]     byte_q, byte_d;
    logic [23:0]    sh_q, sh_d;
    logic [TAW-1:0] addr_q, addr_d, wr_q, wr_d;
    logic           busy_q, busy_d, done_q, done_d, sio_c_q, sio_c_d, oe_q, oe_d, rst_q, rst_d;
    logic           cnt_zero, qend, last, bus_st;

    assign cnt_zero = cnt_q == '0;
    assign qend     = cnt_zero && ph_q == 2'd3;
    assign last     = &addr_q;
    assign bus_st   = state_q inside {START, SHIFT, STOP, GAP};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        // All bus states share one quarter-phase timebase.
        if (bus_st) begin
            cnt_d = cnt_zero ? CW'(QUARTER_CYC - 1) : cnt_q - CW'(1);
            ph_d  = cnt_zero ? ph_q + 2'd1 : ph_q;
        end
        unique case (state_q)
            IDLE, DONE_ST: if (start_i) begin
                state_d = PWR_LO;
                cnt_d   = CW'(POWERUP_CYC - 1);
                addr_d  = '0;
                wr_d    = '0;
            end
            PWR_LO: begin
                state_d = cnt_zero ? PWR_HI : PWR_LO;
                cnt_d   = cnt_zero ? CW'(POWERUP_CYC - 1) : cnt_q - CW'(1);
            end
            PWR_HI: begin
                state_d = cnt_zero ? FETCH : PWR_HI;
                cnt_d   = cnt_q - CW'(1);
            end
            FETCH: state_d = DECODE;
            DECODE: begin
                if (tbl_data_i == 16'hFFFF) state_d = DONE_ST;
                else if (tbl_data_i == 16'hFFF0) begin
                    state_d = DELAY;
                    cnt_d   = CW'(DELAY_CYC - 1);
                end else begin
                    state_d = START;
                    cnt_d   = CW'(QUARTER_CYC - 1);
                    ph_d    = 2'd0;
                    sh_d    = {DEV_ID, tbl_data_i};
                end
            end
            DELAY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_zero) begin
                    state_d = last ? DONE_ST : FETCH;
                    addr_d  = last ? addr_q : addr_q + TAW'(1);
                end
            end
            START: if (qend) begin
                state_d = SHIFT;
                bit_d   = 4'd0;
                byte_d  = 2'd0;
            end
            SHIFT: if (qend) begin
                bit_d   = bit_q == 4'd8 ? 4'd0 : bit_q + 4'd1;
                byte_d  = bit_q == 4'd8 ? byte_q + 2'd1 : byte_q;
                sh_d    = bit_q == 4'd8 ? sh_q : {sh_q[22:0], 1'b0};
                state_d = (bit_q == 4'd8 && byte_q == 2'd2) ? STOP : SHIFT;
            end
            STOP: if (qend) state_d = GAP;
            GAP: if (qend) begin
                wr_d    = &wr_q ? wr_q : wr_q + TAW'(1);
                state_d = last ? DONE_ST : FETCH;
                addr_d  = last ? addr_q : addr_q + TAW'(1);
            end
            default: state_d = IDLE;
        endcase
        // Outputs are registered from next-state values so the pins never glitch.
        sio_c_d = state_d == START ? ph_d != 2'd3 :
                  state_d == SHIFT ? ph_d[1] :
                  state_d == STOP  ? ph_d != 2'd0 : 1'b1;
        oe_d    = state_d == START ? ph_d[1] :
                  state_d == SHIFT ? (bit_d != 4'd8 && !sh_d[23]) :
                  state_d == STOP  ? !ph_d[1] : 1'b0;
        busy_d  = !(state_d inside {IDLE, DONE_ST});
        done_d  = state_d == DONE_ST;
        rst_d   = state_d != PWR_LO;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            wr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sio_c_q <= 1'b1;
            oe_q    <= 1'b0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sio_c_q <= sio_c_d;
            oe_q    <= oe_d;
            rst_q   <= rst_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign tbl_addr_o  = addr_q;
    assign wr_count_o  = wr_q;
    assign sio_c_o     = sio_c_q;
    assign sio_d_oe_o  = oe_q;
    assign cam_rst_n_o = rst_q;
    assign cam_pwdn_o  = 1'b0;
endmodule

// File: tb/tb_cam_sccb_config.sv
// tb_cam_sccb_config: directed checks of power-up, SCCB byte stream, delays,
// start filtering, async reset and table-end handling.
module tb_cam_sccb_config;
    logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, start2 = 1'b0, mon_clr = 1'b0;
    logic busy, done, sio_c, sio_d_oe, cam_rst_n, cam_pwdn;
    logic [7:0] tbl_addr, wr_count;
    logic [15:0] tbl_data, tbl_data2;
    logic busy2, done2, sio_c2, sio_d_oe2, cam_rst_n2, cam_pwdn2;
    logic [1:0] tbl_addr2, wr_count2;
    logic [15:0] rom [256];
    logic [15:0] rom2 [4];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    cam_sccb_config #(.QUARTER_CYC(2), .POWERUP_CYC(10), .DELAY_CYC(20), .DEV_ID(8'h42), .TAW(8)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .busy_o(busy), .done_o(done),
        .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data), .sio_c_o(sio_c), .sio_d_oe_o(sio_d_oe),
        .cam_rst_n_o(cam_rst_n), .cam_pwdn_o(cam_pwdn), .wr_count_o(wr_count));

    cam_sccb_config #(.QUARTER_CYC(2), .POWERUP_CYC(10), .DELAY_CYC(20), .DEV_ID(8'h42), .TAW(2)) dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start2), .busy_o(busy2), .done_o(done2),
        .tbl_addr_o(tbl_addr2), .tbl_data_i(tbl_data2), .sio_c_o(sio_c2), .sio_d_oe_o(sio_d_oe2),
        .cam_rst_n_o(cam_rst_n2), .cam_pwdn_o(cam_pwdn2), .wr_count_o(wr_count2));

    always @(posedge clk) tbl_data <= rom[tbl_addr];
    always @(posedge clk) tbl_data2 <= rom2[tbl_addr2];

    // Bus decoder: samples on the falling clock edge, SIO_D = ~sio_d_oe.
    int scl_rise, scl_edges, n_start, n_stop, ninth_bad, done_rise, rel_run, bi, rise2;
    logic [7:0] cur;
    logic [7:0] bytes_q [$];
    int runs_q [$];
    logic p_sc, p_sd, p_done, p_sc2;
    logic sd;
    assign sd = ~sio_d_oe;

    always @(negedge clk) begin
        if (mon_clr) begin
            scl_rise = 0; scl_edges = 0; n_start = 0; n_stop = 0; ninth_bad = 0;
            done_rise = 0; rel_run = 0; bi = 0; cur = 8'h00; rise2 = 0;
            bytes_q.delete();
            runs_q.delete();
        end else begin
            if (p_sc && sio_c && p_sd && !sd) begin
                n_start++;
                runs_q.push_back(rel_run);
                bi = 0;
            end else if (p_sc && sio_c && !p_sd && sd) begin
                n_stop++;
                bi = 0;
            end else if (!p_sc && sio_c) begin
                scl_rise++;
                if (bi < 8) cur = {cur[6:0], sd};
                else begin
                    bytes_q.push_back(cur);
                    if (!sd) ninth_bad++;
                end
                bi = (bi == 8) ? 0 : bi + 1;
            end
            if (p_sc != sio_c) scl_edges++;
            if (!p_done && done) done_rise++;
            if (!p_sc2 && sio_c2) rise2++;
            rel_run = sio_d_oe ? 0 : rel_run + 1;
        end
        p_sc = sio_c; p_sd = sd; p_done = done; p_sc2 = sio_c2;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon;
        tick; mon_clr = 1'b1;
        tick; mon_clr = 1'b0;
    endtask

    task automatic pulse_start;
        tick; start = 1'b1;
        tick; start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done) begin ok = 1'b1; break; end
            tick;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick; tick;
        checks++;
        if ({busy, done, tbl_addr, sio_c, sio_d_oe, cam_rst_n, cam_pwdn, wr_count} !== {2'b00, 8'h00, 4'b1010, 8'h00}) begin
            failures++;
            $display("FAIL reset_values: got busy=%b done=%b addr=%0h sc=%b oe=%b rst_n=%b pwdn=%b wr=%0h exp 0 0 0 1 0 1 0 0",
                     busy, done, tbl_addr, sio_c, sio_d_oe, cam_rst_n, cam_pwdn, wr_count);
        end
        reset_n = 1'b1;
        tick; tick;
        checks++;
        if ({busy, done, sio_c, sio_d_oe} !== 4'b0010) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b sc=%b oe=%b exp 0 0 1 0", busy, done, sio_c, sio_d_oe);
        end
    endtask

    task automatic test_empty_table;
        int lo, hi;
        lo = 0; hi = 0;
        rom[0] = 16'hFFFF;
        clear_mon;
        pulse_start;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (!cam_rst_n) lo++;
            else if (busy) hi++;
            tick;
        end
        checks++;
        if (lo !== 10) begin failures++; $display("FAIL pwr_lo_cycles: got %0d exp 10", lo); end
        checks++;
        if (hi !== 12) begin failures++; $display("FAIL pwr_hi_to_decode_cycles: got %0d exp 12", hi); end
        checks++;
        if ({done, busy, wr_count, tbl_addr} !== {2'b10, 8'h00, 8'h00}) begin
            failures++;
            $display("FAIL empty_done: got done=%b busy=%b wr=%0h addr=%0h exp 1 0 0 0", done, busy, wr_count, tbl_addr);
        end
        checks++;
        if (scl_edges !== 0) begin failures++; $display("FAIL empty_no_scl: got %0d edges exp 0", scl_edges); end
    endtask

    task automatic test_single_write;
        int n;
        logic [7:0] exp_b [3];
        exp_b = '{8'h42, 8'h12, 8'h80};
        rom[0] = 16'h1280; rom[1] = 16'hFFFF;
        clear_mon;
        pulse_start;
        n = 0;
        for (int i = 0; i < 2000 && !sio_d_oe; i++) @(negedge clk);
        for (int i = 0; i < 2000 && busy; i++) begin n++; @(negedge clk); end
        checks++;
        if (n !== 238) begin failures++; $display("FAIL txn_cycles_from_start_cond: got %0d exp 238", n); end
        checks++;
        if (bytes_q.size() !== 3) begin failures++; $display("FAIL single_nbytes: got %0d exp 3", bytes_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bytes_q[i] !== exp_b[i]) begin failures++; $display("FAIL single_byte%0d: got %0h exp %0h", i, bytes_q[i], exp_b[i]); end
        end
        checks++;
        if ({n_start, n_stop, ninth_bad} !== {32'd1, 32'd1, 32'd0}) begin
            failures++;
            $display("FAIL single_framing: got start=%0d stop=%0d ninth_driven=%0d exp 1 1 0", n_start, n_stop, ninth_bad);
        end
        tick;
        checks++;
        if ({done, wr_count} !== {1'b1, 8'h01}) begin failures++; $display("FAIL single_wr_count: got done=%b wr=%0h exp 1 1", done, wr_count); end
    endtask

    task automatic test_delay;
        bit ok;
        logic [7:0] exp_b [6];
        exp_b = '{8'h42, 8'h11, 8'h01, 8'h42, 8'h6B, 8'h4A};
        rom[0] = 16'h1101; rom[1] = 16'hFFF0; rom[2] = 16'h6B4A; rom[3] = 16'hFFFF;
        clear_mon;
        pulse_start;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL delay_timeout: got done=%b exp 1", done); end
        checks++;
        if (bytes_q.size() !== 6) begin failures++; $display("FAIL delay_nbytes: got %0d exp 6", bytes_q.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bytes_q[i] !== exp_b[i]) begin failures++; $display("FAIL delay_byte%0d: got %0h exp %0h", i, bytes_q[i], exp_b[i]); end
        end
        checks++;
        if (runs_q.size() !== 2 || runs_q[1] !== 40) begin
            failures++;
            $display("FAIL delay_released_gap: got starts=%0d gap=%0d exp 2 40", runs_q.size(), runs_q[1]);
        end
        checks++;
        if ({wr_count, tbl_addr} !== {8'h02, 8'h03}) begin failures++; $display("FAIL delay_counts: got wr=%0h addr=%0h exp 2 3", wr_count, tbl_addr); end
    endtask

    task automatic test_start_ignored;
        bit ok;
        logic [7:0] exp_b [3];
        exp_b = '{8'h42, 8'h12, 8'h80};
        rom[0] = 16'h1280; rom[1] = 16'hFFFF; rom[2] = 16'hFFFF;
        clear_mon;
        pulse_start;
        for (int i = 0; i < 2000 && scl_rise < 3; i++) tick;
        pulse_start;
        wait_done(ok);
        tick; tick;
        checks++;
        if (!ok || done_rise !== 1) begin failures++; $display("FAIL ignored_done_rises: got %0d exp 1", done_rise); end
        checks++;
        if (n_start !== 1 || bytes_q.size() !== 3) begin
            failures++;
            $display("FAIL ignored_stream: got starts=%0d bytes=%0d exp 1 3", n_start, bytes_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bytes_q[i] !== exp_b[i]) begin failures++; $display("FAIL ignored_byte%0d: got %0h exp %0h", i, bytes_q[i], exp_b[i]); end
        end
        checks++;
        if (wr_count !== 8'h01) begin failures++; $display("FAIL ignored_wr_count: got %0h exp 1", wr_count); end
    endtask

    task automatic test_async_reset;
        bit ok;
        clear_mon;
        pulse_start;
        for (int i = 0; i < 2000 && !(scl_rise == 14 && !sio_c); i++) tick;
        checks++;
        if ({sio_c, sio_d_oe, busy} !== 3'b011) begin
            failures++;
            $display("FAIL pre_reset_bit5: got sc=%b oe=%b busy=%b exp 0 1 1", sio_c, sio_d_oe, busy);
        end
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({sio_c, sio_d_oe, busy} !== 3'b100) begin
            failures++;
            $display("FAIL async_release: got sc=%b oe=%b busy=%b exp 1 0 0", sio_c, sio_d_oe, busy);
        end
        tick; tick;
        reset_n = 1'b1;
        clear_mon;
        pulse_start;
        checks++;
        if ({cam_rst_n, busy, tbl_addr} !== {2'b01, 8'h00}) begin
            failures++;
            $display("FAIL rerun_powerup: got rst_n=%b busy=%b addr=%0h exp 0 1 0", cam_rst_n, busy, tbl_addr);
        end
        wait_done(ok);
        checks++;
        if (!ok || wr_count !== 8'h01 || bytes_q.size() !== 3 || bytes_q[1] !== 8'h12) begin
            failures++;
            $display("FAIL rerun_result: got done=%b wr=%0h bytes=%0d reg=%0h exp 1 1 3 12", done, wr_count, bytes_q.size(), bytes_q[1]);
        end
    endtask

    task automatic test_no_end_marker;
        bit ok;
        ok = 1'b0;
        rom2[0] = 16'h0101; rom2[1] = 16'h0202; rom2[2] = 16'h0303; rom2[3] = 16'h0404;
        clear_mon;
        tick; start2 = 1'b1;
        tick; start2 = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (done2) begin ok = 1'b1; break; end
            tick;
        end
        checks++;
        if (!ok || busy2 !== 1'b0) begin failures++; $display("FAIL noend_done: got done=%b busy=%b exp 1 0", done2, busy2); end
        checks++;
        if ({tbl_addr2, wr_count2} !== 4'b1111) begin failures++; $display("FAIL noend_counts: got addr=%0d wr=%0d exp 3 3", tbl_addr2, wr_count2); end
        checks++;
        if (rise2 !== 112) begin failures++; $display("FAIL noend_scl_rises: got %0d exp 112", rise2); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        for (int i = 0; i < 4; i++) rom2[i] = 16'hFFFF;
        test_reset;
        test_empty_table;
        test_single_write;
        test_delay;
        test_start_ignored;
        test_async_reset;
        test_no_end_marker;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
